// File: rtl/regfile_mp.sv
// Multi-port register file with optional write bypass, hardwired R0 and
// a per-register pending scoreboard for RAW stall detection.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   rd_addr / rd_data        NUM_RD combinational read ports, packed
//   rd_pending               registered pending bit per read port
//   wr_en/wr_addr/wr_data    NUM_WR write ports, higher index wins
//   pend_set / pend_addr     mark a register as having a result in flight
//   pend_any                 OR of all pending bits
module regfile_mp #(
  parameter int DW      = 32,
  parameter int DEPTH   = 32,
  parameter int NUM_RD  = 2,
  parameter int NUM_WR  = 1,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD*DW-1:0] rd_data,
  output logic [NUM_RD-1:0]    rd_pending,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic [NUM_WR*DW-1:0] wr_data,
  input  logic                 pend_set,
  input  logic [AW-1:0]        pend_addr,
  output logic                 pend_any
);

  typedef enum logic {
    P_IDLE = 1'b0,
    P_PEND = 1'b1
  } pend_st_t;

  logic [DW-1:0] mem    [DEPTH];
  pend_st_t      pend_q [DEPTH];
  pend_st_t      pend_d [DEPTH];

  logic [NUM_WR-1:0] wr_ok;
  logic [DEPTH-1:0]  wr_hit;
  logic [DEPTH-1:0]  set_hit;
  logic [DEPTH-1:0]  pend_vec;
  logic              set_ok;

  // Out-of-range addresses and (optionally) R0 behave as absent registers.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < 32'(DEPTH)) &&
           !((ZERO_R0 != 0) && (a == '0));
  endfunction

  always_comb begin
    for (int j = 0; j < NUM_WR; j++) begin
      wr_ok[j] = wr_en[j] && addr_ok(wr_addr[j*AW +: AW]);
    end
  end

  assign set_ok = pend_set && addr_ok(pend_addr);

  always_comb begin
    wr_hit  = '0;
    set_hit = '0;
    for (int r = 0; r < DEPTH; r++) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_ok[j] && (wr_addr[j*AW +: AW] == AW'(r))) begin
          wr_hit[r] = 1'b1;
        end
      end
      set_hit[r] = set_ok && (pend_addr == AW'(r));
    end
  end

  // Loop order makes the higher-index port win on an address clash.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_ok[j]) begin
          mem[wr_addr[j*AW +: AW]] <= wr_data[j*DW +: DW];
        end
      end
    end
  end

  // Per-register pending FSM; a new producer beats a completing write.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      pend_d[r] = pend_q[r];
      unique case (pend_q[r])
        P_IDLE: begin
          if (set_hit[r]) pend_d[r] = P_PEND;
        end
        P_PEND: begin
          if (set_hit[r])     pend_d[r] = P_PEND;
          else if (wr_hit[r]) pend_d[r] = P_IDLE;
        end
        default: pend_d[r] = P_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        pend_q[r] <= P_IDLE;
      end
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        pend_q[r] <= pend_d[r];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      pend_vec[r] = (pend_q[r] == P_PEND);
    end
  end

  assign pend_any = |pend_vec;

  // rst gating keeps a bypassed write from leaking out during reset.
  always_comb begin
    rd_data    = '0;
    rd_pending = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (!rst && addr_ok(rd_addr[i*AW +: AW])) begin
        rd_data[i*DW +: DW] = mem[rd_addr[i*AW +: AW]];
        rd_pending[i]       = pend_vec[rd_addr[i*AW +: AW]];
        if (BYPASS != 0) begin
          for (int j = 0; j < NUM_WR; j++) begin
            if (wr_ok[j] &&
                (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
              rd_data[i*DW +: DW] = wr_data[j*DW +: DW];
            end
          end
        end
      end
    end
  end

endmodule
